// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state encoding and the default byte width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } uart_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after `last`, wrapping mod NUM_REQ.
// Zero latency; no grant when no request is set.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx
);

  int               cand;
  logic [IDX_W-1:0] cidx;
  logic             found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = 0;
    cidx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found            = 1'b1;
        gnt_onehot[cidx] = 1'b1;
        gnt_idx          = cidx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter: accept at T, start pulse at T+1, hold until done/watchdog.
// Requesters see ready only in IDLE, so a byte waits in its producer while the transmitter is busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [TIMEOUT_WIDTH-1:0]      timeout_i,
  output logic                          tx_start_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_done_i,
  output logic [IDX_W-1:0]              grant_id_o,
  output logic                          busy_o,
  output logic                          timeout_err_o
);

  uart_arb_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [IDX_W-1:0]         grant_q;
  logic [IDX_W-1:0]         last_q;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt_q;
  logic [NUM_REQ-1:0]       arb_onehot;
  logic [IDX_W-1:0]         arb_idx;
  logic                     wd_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid_i),
    .last       (last_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  // Limit reached; a zero limit means the watchdog never fires.
  assign wd_hit = (timeout_i != '0) && (wait_cnt_q == timeout_i - TIMEOUT_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (|req_valid_i) state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done_i || wd_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Pulses are suppressed while reset is held so a reset edge never emits start or error.
  always_comb begin
    req_ready_o   = '0;
    tx_start_o    = 1'b0;
    timeout_err_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE:      req_ready_o   = arb_onehot;
        START:     tx_start_o    = 1'b1;
        WAIT_DONE: timeout_err_o = wd_hit && !tx_done_i;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q     <= '0;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            data_q  <= req_data_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            grant_q <= arb_idx;
          end
        end
        START: wait_cnt_q <= '0;
        WAIT_DONE: begin
          if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + TIMEOUT_WIDTH'(1);
          if (tx_done_i || wd_hit) last_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

  assign tx_data_o  = data_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round-robin order, watchdog,
// done/timeout tie, spurious done, disabled watchdog and mid-frame reset.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TW      = 16;
  localparam int IW      = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ*DW-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [TW-1:0]        timeout_i;
  logic                 tx_start_o;
  logic [DW-1:0]        tx_data_o;
  logic                 tx_done_i;
  logic [IW-1:0]        grant_id_o;
  logic                 busy_o;
  logic                 timeout_err_o;

  int vectors = 0;
  int errors  = 0;

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_WIDTH    (DW),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .timeout_i     (timeout_i),
    .tx_start_o    (tx_start_o),
    .tx_data_o     (tx_data_o),
    .tx_done_i     (tx_done_i),
    .grant_id_o    (grant_id_o),
    .busy_o        (busy_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant_id_o), 32'd0);
    check({tag, "_data"},  32'(tx_data_o),  32'd0);
    check({tag, "_start"}, 32'(tx_start_o), 32'd0);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o),     32'd0);
    check({tag, "_err"},   32'(timeout_err_o), 32'd0);
  endtask

  initial begin
    logic err_seen;
    int   exp_id;

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    timeout_i   = '0;
    tx_done_i   = 1'b0;

    // Reset values, while held and after release
    tick(); tick();
    check_idle_outputs("rst_held");
    rst_i = 1'b0;
    #1;
    check_idle_outputs("rst_rel");

    // Single request on requester 2, done 20 cycles after start
    req_data_i  = 32'h00A5_0000;
    req_valid_i = 4'b0100;
    #1;
    check("single_ready_T", 32'(req_ready_o), 32'h4);
    tick();
    req_valid_i = '0;
    #1;
    check("single_start", 32'(tx_start_o), 32'd1);
    check("single_data",  32'(tx_data_o),  32'hA5);
    check("single_grant", 32'(grant_id_o), 32'd2);
    check("single_busy",  32'(busy_o),     32'd1);
    check("single_ready_start", 32'(req_ready_o), 32'd0);
    tick();
    check("single_start_once", 32'(tx_start_o), 32'd0);
    repeat (19) tick();
    check("single_data_stable", 32'(tx_data_o), 32'hA5);
    tx_done_i = 1'b1;
    #1;
    check("single_busy_at_done", 32'(busy_o), 32'd1);
    tick();
    tx_done_i = 1'b0;
    #1;
    check("single_idle_after_done", 32'(busy_o), 32'd0);

    // Round robin from a fresh reset: order 0,1,2,3,0, starts 7 cycles apart
    rst_i = 1'b1;
    tick();
    rst_i       = 1'b0;
    req_data_i  = 32'h1312_1110;
    req_valid_i = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % NUM_REQ;
      check($sformatf("rr%0d_ready", g), 32'(req_ready_o), 32'(1 << exp_id));
      tick();
      check($sformatf("rr%0d_start", g), 32'(tx_start_o), 32'd1);
      check($sformatf("rr%0d_grant", g), 32'(grant_id_o), 32'(exp_id));
      check($sformatf("rr%0d_data", g),  32'(tx_data_o),  32'(8'h10 + exp_id));
      tick();
      check($sformatf("rr%0d_nostart", g), 32'(tx_start_o), 32'd0);
      repeat (4) tick();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      #1;
    end
    req_valid_i = '0;
    #1;

    // Watchdog: limit 8, requesters 0 and 1 valid, last grant was 0 so 1 wins
    timeout_i   = 16'd8;
    req_data_i  = 32'h4433_2211;
    req_valid_i = 4'b0011;
    #1;
    check("wd_ready", 32'(req_ready_o), 32'h2);
    tick();
    check("wd_grant", 32'(grant_id_o), 32'd1);
    check("wd_data",  32'(tx_data_o),  32'h22);
    tick();
    check("wd_err_entry", 32'(timeout_err_o), 32'd0);
    repeat (6) tick();
    check("wd_err_early", 32'(timeout_err_o), 32'd0);
    tick();
    check("wd_err_pulse", 32'(timeout_err_o), 32'd1);
    check("wd_busy_pulse", 32'(busy_o), 32'd1);
    tick();
    check("wd_err_cleared", 32'(timeout_err_o), 32'd0);
    check("wd_idle", 32'(busy_o), 32'd0);
    check("wd_next_ready", 32'(req_ready_o), 32'h1);
    tick();
    check("wd_next_grant", 32'(grant_id_o), 32'd0);
    check("wd_next_start", 32'(tx_start_o), 32'd1);

    // Done in the same cycle the limit is reached
    repeat (8) tick();
    req_valid_i = '0;
    tx_done_i   = 1'b1;
    #1;
    check("tie_no_err", 32'(timeout_err_o), 32'd0);
    tick();
    tx_done_i = 1'b0;
    #1;
    check("tie_idle", 32'(busy_o), 32'd0);
    check("tie_err_after", 32'(timeout_err_o), 32'd0);

    // Spurious done in IDLE
    tx_done_i = 1'b1;
    tick();
    tx_done_i = 1'b0;
    #1;
    check("spur_busy",  32'(busy_o),     32'd0);
    check("spur_start", 32'(tx_start_o), 32'd0);
    check("spur_grant", 32'(grant_id_o), 32'd0);

    // Disabled watchdog over a 1000-cycle wait; last grant 0 so requester 3 wins
    timeout_i   = '0;
    req_valid_i = 4'b1000;
    #1;
    check("nowd_ready", 32'(req_ready_o), 32'h8);
    tick();
    req_valid_i = '0;
    check("nowd_grant", 32'(grant_id_o), 32'd3);
    check("nowd_data",  32'(tx_data_o),  32'h44);
    err_seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      err_seen = err_seen | timeout_err_o;
    end
    check("nowd_no_err", 32'(err_seen), 32'd0);
    check("nowd_busy",   32'(busy_o),   32'd1);
    tx_done_i = 1'b1;
    tick();
    tx_done_i = 1'b0;
    #1;
    check("nowd_idle", 32'(busy_o), 32'd0);

    // Reset in WAIT_DONE; last grant 3 so requester 2 wins first
    timeout_i   = 16'd4;
    req_valid_i = 4'b0100;
    #1;
    tick();
    req_valid_i = '0;
    check("mid_grant", 32'(grant_id_o), 32'd2);
    tick(); tick(); tick();
    rst_i = 1'b1;
    #1;
    check("mid_rst_no_err", 32'(timeout_err_o), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check_idle_outputs("mid_after");
    req_valid_i = 4'hF;
    #1;
    check("mid_ready_r0", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = '0;
    check("mid_grant_r0", 32'(grant_id_o), 32'd0);
    check("mid_data_r0",  32'(tx_data_o),  32'h11);
    check("mid_start_r0", 32'(tx_start_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
